// File: rtl/multi_seven_seg.sv
// rtl/multi_seven_seg.sv - N-digit multiplexed seven-segment driver with dead-time and per-frame snapshot
// Includes the seven_segment hex decoder it reuses.

module seven_segment (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  // Active-low segments, seg[0] = a ... seg[6] = g.
  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end
endmodule

module multi_seven_seg #(
  parameter int NUM_DIGITS  = 2,
  parameter int REFRESH_DIV = 24000,
  parameter int DEAD_CYCLES = 480
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [4*NUM_DIGITS-1:0]                         digits,
  input  logic [NUM_DIGITS-1:0]                           digit_en,
  input  logic                                            lz_blank,
  output logic [NUM_DIGITS-1:0]                           anode,
  output logic [6:0]                                      seg,
  output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
  output logic                                            frame_tick
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [4*NUM_DIGITS-1:0] snap;
  logic                    frame_start;
  logic                    upper_zero;
  logic [NUM_DIGITS-1:0]   suppress;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [3:0]              cur_nibble;
  logic                    cur_en;
  logic                    cur_sup;
  logic                    lit;
  logic [6:0]              dec_seg;

  seven_segment u_dec (
    .hex (cur_nibble),
    .seg (dec_seg)
  );

  // Blanking scans from the top digit down over the frozen snapshot.
  always_comb begin
    upper_zero = 1'b1;
    suppress   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero  = upper_zero && (snap[4*i +: 4] == 4'h0);
      suppress[i] = lz_blank && upper_zero && (i != 0);
    end
  end

  always_comb begin
    cur_nibble = 4'h0;
    cur_en     = 1'b0;
    cur_sup    = 1'b0;
    onehot     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IW'(i)) begin
        cur_nibble = snap[4*i +: 4];
        cur_en     = digit_en[i];
        cur_sup    = suppress[i];
        onehot[i]  = 1'b1;
      end
    end
    frame_start = (cnt == '0) && (digit_idx == '0);
    lit         = (cnt >= CNT_DEAD) && cur_en && !cur_sup;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      digit_idx  <= '0;
      snap       <= '0;
      frame_tick <= 1'b0;
      anode      <= '0;
      seg        <= 7'h7F;
    end else begin
      frame_tick <= frame_start;
      if (frame_start) begin
        snap <= digits;
      end
      if (cnt == CNT_LAST) begin
        cnt       <= '0;
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // Outputs follow the slot state by one cycle.
      anode <= lit ? onehot : '0;
      seg   <= lit ? dec_seg : 7'h7F;
    end
  end
endmodule

// File: tb/tb_multi_seven_seg.sv
// tb/tb_multi_seven_seg.sv - directed self-checking bench for multi_seven_seg
// Drives a 4/8/2 instance through frame sequences and a 1/4/1 instance after a mid-slot reset.

module tb_multi_seven_seg;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  digit_en;
  logic        lz_blank;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  logic [3:0]  digits2;
  logic        digit_en2;
  logic        anode2;
  logic [6:0]  seg2;
  logic        digit_idx2;
  logic        frame_tick2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_seven_seg #(.NUM_DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .digits     (digits),
    .digit_en   (digit_en),
    .lz_blank   (lz_blank),
    .anode      (anode),
    .seg        (seg),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  multi_seven_seg #(.NUM_DIGITS(1), .REFRESH_DIV(4), .DEAD_CYCLES(1)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .digits     (digits2),
    .digit_en   (digit_en2),
    .lz_blank   (lz_blank),
    .anode      (anode2),
    .seg        (seg2),
    .digit_idx  (digit_idx2),
    .frame_tick (frame_tick2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts on the negedge where frame_tick is high; ends on the next one.
  // segs = {slot3, slot2, slot1, slot0} expected patterns for lit slots.
  task automatic check_frame(input string tag, input logic [3:0] mask, input logic [27:0] segs,
                             input int chg_j, input logic [15:0] chg_val);
    for (int j = 0; j < 32; j++) begin
      int slot;
      int ph;
      logic on;
      slot = j / 8;
      ph   = j % 8;
      on   = (ph >= 2) && mask[slot];
      chk({tag, " anode"}, anode, on ? (32'd1 << slot) : 32'd0);
      chk({tag, " seg"}, seg, on ? segs[7*slot +: 7] : 7'h7F);
      chk({tag, " frame_tick"}, frame_tick, (j == 0) ? 1 : 0);
      chk({tag, " digit_idx"}, digit_idx, ((j + 1) / 8) % 4);
      chk({tag, " onehot0"}, $onehot0(anode), 1);
      if (j == chg_j) digits = chg_val;
      @(negedge clk);
    end
  endtask

  initial begin
    reset     = 1'b1;
    digits    = 16'h1234;
    digit_en  = 4'hF;
    lz_blank  = 1'b0;
    digits2   = 4'h5;
    digit_en2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst anode", anode, 0);
    chk("rst seg", seg, 7'h7F);
    chk("rst digit_idx", digit_idx, 0);
    chk("rst frame_tick", frame_tick, 0);
    chk("rst anode2", anode2, 0);
    chk("rst seg2", seg2, 7'h7F);

    reset = 1'b0;
    @(negedge clk);
    check_frame("f1_1234", 4'hF, {7'h79, 7'h24, 7'h30, 7'h19}, 99, 16'h0);
    check_frame("f2_tear", 4'hF, {7'h79, 7'h24, 7'h30, 7'h19}, 10, 16'hABCD);
    check_frame("f3_abcd", 4'hF, {7'h08, 7'h03, 7'h46, 7'h21}, 99, 16'h0);

    digits   = 16'h0070;
    lz_blank = 1'b1;
    check_frame("f4_abcd_lz", 4'hF, {7'h08, 7'h03, 7'h46, 7'h21}, 99, 16'h0);
    check_frame("f5_0070", 4'b0011, {7'h7F, 7'h7F, 7'h78, 7'h40}, 99, 16'h0);
    digits = 16'h0000;
    check_frame("f6_0070", 4'b0011, {7'h7F, 7'h7F, 7'h78, 7'h40}, 99, 16'h0);
    check_frame("f7_0000", 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 99, 16'h0);

    lz_blank = 1'b0;
    digit_en = 4'b0101;
    digits   = 16'h1234;
    check_frame("f8_en_zero", 4'b0101, {7'h7F, 7'h40, 7'h7F, 7'h40}, 99, 16'h0);
    check_frame("f9_en_1234", 4'b0101, {7'h7F, 7'h24, 7'h7F, 7'h19}, 99, 16'h0);

    digit_en = 4'hF;
    repeat (20) @(negedge clk);
    chk("pre_rst anode", anode, 4'b0100);
    chk("pre_rst seg", seg, 7'h24);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst anode", anode, 0);
    chk("mid_rst seg", seg, 7'h7F);
    chk("mid_rst digit_idx", digit_idx, 0);
    chk("mid_rst frame_tick", frame_tick, 0);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      logic on2;
      @(negedge clk);
      if (k <= 3) begin
        chk("rel frame_tick", frame_tick, (k == 1) ? 1 : 0);
        chk("rel anode", anode, (k == 3) ? 4'b0001 : 4'b0000);
        chk("rel seg", seg, (k == 3) ? 7'h19 : 7'h7F);
      end
      on2 = ((k - 1) % 4) >= 1;
      chk("one anode", anode2, on2);
      chk("one seg", seg2, on2 ? 7'h12 : 7'h7F);
      chk("one frame_tick", frame_tick2, (((k - 1) % 4) == 0) ? 1 : 0);
      chk("one digit_idx", digit_idx2, 0);
      chk("onehot0", $onehot0(anode), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
